quic_dec_seq: RTL and testbench

Parametrised sequencer for the QUIC image decoder. It replaces the fixed three-channel decode FSM with a controller that supports:
- a configurable channel count, dimension width, header length and model-update depth;
- explicit valid/ready handshakes on both the symbol side and the pixel side;
- run-length truncation at row end.

It sits between the bit-reader/Golomb front end and the pixel reconstruction/output stage, and owns the image row/column position.

---
 rtl/quic_dec_seq_pkg.sv | 25 ++
 rtl/quic_dec_seq_if.sv | 44 ++++
 rtl/quic_dec_seq_pos_cnt.sv | 53 +++++
 rtl/quic_dec_seq.sv | 197 +++++++++++++++++++
 tb/tb_quic_dec_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/quic_dec_seq_pkg.sv
// Shared definitions for the QUIC decode sequencer: state encoding,
// header word offsets and the width helper used for index ports.
package quic_dec_pkg;

   // Sequencer state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_HDR       = 3'd1;
   localparam state_t ST_PIX_START = 3'd2;
   localparam state_t ST_GOLOMB    = 3'd3;
   localparam state_t ST_UPDATE    = 3'd4;
   localparam state_t ST_EMIT      = 3'd5;
   localparam state_t ST_RUN_LEN   = 3'd6;
   localparam state_t ST_RUN_EMIT  = 3'd7;

   // Image sizes are the last two header words, counted back from the end
   localparam int HDR_OFS_WIDTH  = 2;
   localparam int HDR_OFS_HEIGHT = 1;

   // Index width for a counter over n values, never narrower than one bit
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/quic_dec_seq_if.sv
// Symbol-side and pixel-side handshake bundle of the decode sequencer.
interface quic_dec_seq_if #(
   parameter int DIM_W   = 16,
   parameter int NUM_CH  = 3,
   parameter int UPD_CYC = 2
);
   localparam int CH_W   = quic_dec_pkg::clog2_min1(NUM_CH);
   localparam int STEP_W = quic_dec_pkg::clog2_min1(UPD_CYC);

   logic              start;
   logic              sym_valid;
   logic [31:0]       sym_data;
   logic              sym_ack;
   logic              run_mode;
   logic              skip_upd;
   logic              pix_ready;
   logic              pix_valid;
   logic              pix_is_run;
   logic [CH_W-1:0]   ch_sel;
   logic              upd_en;
   logic [STEP_W-1:0] upd_step;
   logic [DIM_W-1:0]  row;
   logic [DIM_W-1:0]  col;
   logic [DIM_W-1:0]  img_width;
   logic [DIM_W-1:0]  img_height;
   logic              busy;
   logic              done;
   logic              err;
   logic              run_trunc;

   // Sequencer side
   modport master (
      input  start, sym_valid, sym_data, run_mode, skip_upd, pix_ready,
      output sym_ack, pix_valid, pix_is_run, ch_sel, upd_en, upd_step,
             row, col, img_width, img_height, busy, done, err, run_trunc
   );

   // Front end / downstream side
   modport slave (
      output start, sym_valid, sym_data, run_mode, skip_upd, pix_ready,
      input  sym_ack, pix_valid, pix_is_run, ch_sel, upd_en, upd_step,
             row, col, img_width, img_height, busy, done, err, run_trunc
   );
endinterface

// File: rtl/quic_dec_seq_pos_cnt.sv
// Row/column position counter with column wrap and end-of-row/image flags.
module quic_dec_pos_cnt #(
   parameter int DIM_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             advance,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic             is_last_col,
   output logic             is_last_pix
);
   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   logic [DIM_W-1:0] row_q, row_d;
   logic [DIM_W-1:0] col_q, col_d;

   assign is_last_col = (col_q == width - ONE);
   assign is_last_pix = is_last_col && (row_q == height - ONE);
   assign row         = row_q;
   assign col         = col_q;

   // Next position: clear wins, otherwise step with wrap at row end
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
      end else if (advance) begin
         if (is_last_col) begin
            col_d = '0;
            row_d = row_q + ONE;
         end else begin
            col_d = col_q + ONE;
         end
      end
   end

   // Position registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end
endmodule

// File: rtl/quic_dec_seq.sv
// QUIC decode sequencer: header capture, per-pixel Golomb/update/emit
// control, run-length copy with truncation at row end.
module quic_dec_seq
   import quic_dec_pkg::*;
#(
   parameter int DIM_W     = 16,
   parameter int NUM_CH    = 3,
   parameter int HDR_WORDS = 5,
   parameter int UPD_CYC   = 2,
   parameter int RUN_W     = 16
) (
   input logic            clk,
   input logic            reset_n,
   quic_dec_seq_if.master bus
);
   localparam int CH_W   = clog2_min1(NUM_CH);
   localparam int STEP_W = clog2_min1(UPD_CYC);
   localparam int IDX_W  = clog2_min1(HDR_WORDS);

   localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(NUM_CH - 1);
   localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(UPD_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_WIDTH  = IDX_W'(HDR_WORDS - HDR_OFS_WIDTH);
   localparam logic [IDX_W-1:0]  IDX_HEIGHT = IDX_W'(HDR_WORDS - HDR_OFS_HEIGHT);
   localparam logic [RUN_W-1:0]  RUN_ONE    = RUN_W'(1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  hdr_idx_q, hdr_idx_d;
   logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
   logic [STEP_W-1:0] upd_step_q, upd_step_d;
   logic [RUN_W-1:0]  remain_q, remain_d;
   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              trunc_q, trunc_d;
   logic              pos_clear, pos_adv;
   logic              last_col, last_pix;
   logic [DIM_W-1:0]  hdr_dim;

   assign hdr_dim = bus.sym_data[DIM_W-1:0];

   quic_dec_pos_cnt #(.DIM_W(DIM_W)) u_pos (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (pos_clear),
      .advance     (pos_adv),
      .width       (width_q),
      .height      (height_q),
      .row         (bus.row),
      .col         (bus.col),
      .is_last_col (last_col),
      .is_last_pix (last_pix)
   );

   // Symbol consumption is the only path from inputs straight to outputs
   assign bus.sym_ack    = bus.sym_valid &&
                           (state_q == ST_HDR || state_q == ST_GOLOMB || state_q == ST_RUN_LEN);
   assign bus.pix_valid  = (state_q == ST_EMIT) || (state_q == ST_RUN_EMIT);
   assign bus.pix_is_run = (state_q == ST_RUN_EMIT);
   assign bus.upd_en     = (state_q == ST_UPDATE);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.ch_sel     = ch_sel_q;
   assign bus.upd_step   = upd_step_q;
   assign bus.img_width  = width_q;
   assign bus.img_height = height_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.run_trunc  = trunc_q;

   // Next-state and datapath control
   always_comb begin
      state_d    = state_q;
      hdr_idx_d  = hdr_idx_q;
      ch_sel_d   = ch_sel_q;
      upd_step_d = upd_step_q;
      remain_d   = remain_q;
      width_d    = width_q;
      height_d   = height_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      trunc_d    = 1'b0;
      pos_clear  = 1'b0;
      pos_adv    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A start landing on the done pulse belongs to the finished image
            if (bus.start && !done_q) begin
               state_d   = ST_HDR;
               hdr_idx_d = '0;
               pos_clear = 1'b1;
            end
         end
         ST_HDR: begin
            if (bus.sym_valid) begin
               hdr_idx_d = hdr_idx_q + IDX_W'(1);
               if (hdr_idx_q == IDX_WIDTH) width_d = hdr_dim;
               if (hdr_idx_q == IDX_HEIGHT) begin
                  height_d = hdr_dim;
                  if (width_q == '0 || hdr_dim == '0) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_PIX_START;
                  end
               end
            end
         end
         ST_PIX_START: begin
            ch_sel_d = '0;
            state_d  = bus.run_mode ? ST_RUN_LEN : ST_GOLOMB;
         end
         ST_GOLOMB: begin
            if (bus.sym_valid) begin
               if (ch_sel_q == CH_LAST) begin
                  upd_step_d = '0;
                  state_d    = bus.skip_upd ? ST_EMIT : ST_UPDATE;
               end else begin
                  ch_sel_d = ch_sel_q + CH_W'(1);
               end
            end
         end
         ST_UPDATE: begin
            if (upd_step_q == STEP_LAST) begin
               upd_step_d = '0;
               state_d    = ST_EMIT;
            end else begin
               upd_step_d = upd_step_q + STEP_W'(1);
            end
         end
         ST_EMIT: begin
            if (bus.pix_ready) begin
               pos_adv = 1'b1;
               if (last_pix) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_PIX_START;
               end
            end
         end
         ST_RUN_LEN: begin
            if (bus.sym_valid) begin
               remain_d = bus.sym_data[RUN_W-1:0];
               ch_sel_d = '0;
               // An empty run still leaves a coded pixel to decode
               state_d  = (bus.sym_data[RUN_W-1:0] == '0) ? ST_GOLOMB : ST_RUN_EMIT;
            end
         end
         ST_RUN_EMIT: begin
            if (bus.pix_ready) begin
               pos_adv  = 1'b1;
               remain_d = remain_q - RUN_ONE;
               if (last_pix) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (last_col && remain_q > RUN_ONE) begin
                  // Runs never cross a row; the tail is dropped
                  trunc_d  = 1'b1;
                  remain_d = '0;
                  state_d  = ST_PIX_START;
               end else if (remain_q == RUN_ONE) begin
                  ch_sel_d = '0;
                  state_d  = ST_GOLOMB;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         hdr_idx_q  <= '0;
         ch_sel_q   <= '0;
         upd_step_q <= '0;
         remain_q   <= '0;
         width_q    <= '0;
         height_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_idx_q  <= hdr_idx_d;
         ch_sel_q   <= ch_sel_d;
         upd_step_q <= upd_step_d;
         remain_q   <= remain_d;
         width_q    <= width_d;
         height_q   <= height_d;
         done_q     <= done_d;
         err_q      <= err_d;
         trunc_q    <= trunc_d;
      end
   end
endmodule

// File: tb/tb_quic_dec_seq.sv
// Scoreboard bench for quic_dec_seq: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_quic_dec_seq;
   localparam int DIM_W = 16;
   localparam int NCH   = 3;
   localparam int UPD   = 2;

   localparam int K_PIX = 0, K_DONE = 1, K_ERR = 2, K_TRUNC = 3;

   typedef struct {
      int kind;
      int row;
      int col;
      bit run;
      int gap;
   } ev_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_pix_cyc = 0;
   int   ack_cnt = 0;
   int   sent_cnt = 0;
   ev_t  exp_q[$];

   always #5 clk = ~clk;

   quic_dec_seq_if #(.DIM_W(DIM_W), .NUM_CH(NCH), .UPD_CYC(UPD)) bus ();

   quic_dec_seq #(.DIM_W(DIM_W), .NUM_CH(NCH), .HDR_WORDS(5), .UPD_CYC(UPD), .RUN_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic mon_event(input int kind, input int r, input int c, input bit run);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d row=%0d col=%0d run=%0d want none", kind, r, c, run);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != kind ||
          (kind == K_PIX && (e.row != r || e.col != c || e.run != run ||
                             (e.gap != 0 && cyc - last_pix_cyc != e.gap)))) begin
         bad++;
         $display("FAIL event: got kind=%0d row=%0d col=%0d run=%0d gap=%0d want kind=%0d row=%0d col=%0d run=%0d gap=%0d",
                  kind, r, c, run, cyc - last_pix_cyc, e.kind, e.row, e.col, e.run, e.gap);
      end else begin
         $display("event ok: kind=%0d row=%0d col=%0d run=%0d", kind, r, c, run);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      cyc++;
      if (reset_n) begin
         if (bus.sym_ack) ack_cnt++;
         if (bus.pix_valid && bus.pix_ready) begin
            mon_event(K_PIX, int'(bus.row), int'(bus.col), bus.pix_is_run);
            last_pix_cyc = cyc;
         end
         if (bus.done)      mon_event(K_DONE, 0, 0, 1'b0);
         if (bus.err)       mon_event(K_ERR, 0, 0, 1'b0);
         if (bus.run_trunc) mon_event(K_TRUNC, 0, 0, 1'b0);
      end
   end

   task automatic push(input int kind, input int r, input int c, input bit run, input int gap);
      ev_t e;
      e.kind = kind; e.row = r; e.col = c; e.run = run; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Present one symbol and hold it until consumed; returns #1 after the accepting edge
   task automatic send_sym(input logic [31:0] d, input bit slow);
      int n;
      if (slow) begin
         bus.sym_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.sym_valid = 1'b1;
      bus.sym_data  = d;
      n = 0;
      @(negedge clk);
      while (!bus.sym_ack && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.sym_ack) begin
         total++; bad++;
         $display("FAIL sym_ack_timeout: got no ack want ack for %0h", d);
      end else begin
         sent_cnt++;
      end
      @(posedge clk); #1;
      bus.sym_valid = 1'b0;
   endtask

   task automatic start_image(input int w, input int h);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      send_sym(32'h0000_1111, 1'b0);
      send_sym(32'h0000_2222, 1'b0);
      send_sym(32'h0000_3333, 1'b0);
      send_sym(32'(w), 1'b0);
      send_sym(32'(h), 1'b0);
   endtask

   task automatic coded_pixel(input int r, input int c, input bit skip, input int gap, input bit slow);
      bus.run_mode = 1'b0;
      bus.skip_upd = skip;
      push(K_PIX, r, c, 1'b0, gap);
      for (int k = 0; k < NCH; k++) send_sym(32'hC0DE_0000 + 32'(k), slow);
   endtask

   // Run of len starting at (r,c); nrun copies are expected before it ends or is clipped
   task automatic run_pixel(input int r, input int c, input int len, input int nrun, input int gap0);
      bus.run_mode = 1'b1;
      for (int i = 0; i < nrun; i++) push(K_PIX, r, c + i, 1'b1, (i == 0) ? gap0 : 1);
      send_sym({16'hABCD, 16'(len)}, 1'b0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         total++; bad++;
         $display("FAIL %s_timeout: got pending=%0d busy=%0d want 0", name, exp_q.size(), bus.busy);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
      chk({tag, "_pix_is_run"}, int'(bus.pix_is_run), 0);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_row"}, int'(bus.row), 0);
      chk({tag, "_col"}, int'(bus.col), 0);
      chk({tag, "_img_width"}, int'(bus.img_width), 0);
      chk({tag, "_img_height"}, int'(bus.img_height), 0);
      chk({tag, "_ch_sel"}, int'(bus.ch_sel), 0);
      chk({tag, "_upd_en"}, int'(bus.upd_en), 0);
      chk({tag, "_upd_step"}, int'(bus.upd_step), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
      chk({tag, "_err"}, int'(bus.err), 0);
      chk({tag, "_run_trunc"}, int'(bus.run_trunc), 0);
      chk({tag, "_sym_ack"}, int'(bus.sym_ack), 0);
   endtask

   initial begin
      int n;
      bus.start = 1'b0; bus.sym_valid = 1'b0; bus.sym_data = '0;
      bus.run_mode = 1'b0; bus.skip_upd = 1'b0; bus.pix_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // 1: 2x2 coded with model update, 7 cycles per pixel
      start_image(2, 2);
      coded_pixel(0, 0, 1'b0, 0, 1'b0);
      coded_pixel(0, 1, 1'b0, 7, 1'b0);
      coded_pixel(1, 0, 1'b0, 7, 1'b0);
      coded_pixel(1, 1, 1'b0, 7, 1'b0);
      push(K_DONE, 0, 0, 1'b0, 0);
      wait_idle("t1");
      chk("t1_busy_after_done", int'(bus.busy), 0);

      // 2: zero width reports err and produces no pixel
      push(K_ERR, 0, 0, 1'b0, 0);
      start_image(0, 2);
      wait_idle("t2");
      chk("t2_busy_after_err", int'(bus.busy), 0);

      // 3: 8x2, run of 3 at col 2, following pixel is coded without PIX_START
      start_image(8, 2);
      coded_pixel(0, 0, 1'b1, 0, 1'b0);
      chk("t3_img_width", int'(bus.img_width), 8);
      chk("t3_img_height", int'(bus.img_height), 2);
      coded_pixel(0, 1, 1'b1, 5, 1'b0);
      run_pixel(0, 2, 3, 3, 3);
      coded_pixel(0, 5, 1'b1, 4, 1'b0);
      for (int c = 6; c < 8; c++) coded_pixel(0, c, 1'b1, 5, 1'b0);
      for (int c = 0; c < 8; c++) coded_pixel(1, c, 1'b1, 5, 1'b0);
      push(K_DONE, 0, 0, 1'b0, 0);
      wait_idle("t3");

      // 4: 4x2, run of 5 at col 2 is clipped after 2 copies
      start_image(4, 2);
      coded_pixel(0, 0, 1'b1, 0, 1'b0);
      coded_pixel(0, 1, 1'b1, 5, 1'b0);
      run_pixel(0, 2, 5, 2, 3);
      push(K_TRUNC, 0, 0, 1'b0, 0);
      coded_pixel(1, 0, 1'b1, 5, 1'b0);
      for (int c = 1; c < 4; c++) coded_pixel(1, c, 1'b1, 5, 1'b0);
      push(K_DONE, 0, 0, 1'b0, 0);
      wait_idle("t4");

      // 5: downstream stall in EMIT with a toggling symbol stream
      bus.pix_ready = 1'b0;
      start_image(2, 2);
      coded_pixel(0, 0, 1'b0, 0, 1'b1);
      n = 0;
      @(negedge clk);
      while (!bus.pix_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t5_pix_valid_reached", int'(bus.pix_valid), 1);
      for (int i = 0; i < 10; i++) begin
         chk("t5_hold_pix_valid", int'(bus.pix_valid), 1);
         chk("t5_hold_row", int'(bus.row), 0);
         chk("t5_hold_col", int'(bus.col), 0);
         chk("t5_hold_no_ack", int'(bus.sym_ack), 0);
         @(posedge clk); #1;
         bus.sym_valid = ~bus.sym_valid;
         bus.sym_data  = 32'hDEAD_0000;
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.sym_valid = 1'b0;
      bus.pix_ready = 1'b1;
      coded_pixel(0, 1, 1'b0, 0, 1'b1);
      coded_pixel(1, 0, 1'b0, 7, 1'b0);
      coded_pixel(1, 1, 1'b0, 7, 1'b0);
      push(K_DONE, 0, 0, 1'b0, 0);
      wait_idle("t5");
      chk("t5_ack_count", ack_cnt, sent_cnt);

      // 6: reset while a run copy is stalled, then a clean image
      start_image(8, 2);
      coded_pixel(0, 0, 1'b1, 0, 1'b0);
      bus.run_mode = 1'b1;
      send_sym({16'h0000, 16'd5}, 1'b0);
      bus.pix_ready = 1'b0;
      @(negedge clk);
      chk("t6_in_run_emit", int'(bus.pix_valid && bus.pix_is_run), 1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      chk_zero("t6_reset");
      reset_n = 1'b1;
      bus.pix_ready = 1'b1;
      bus.run_mode = 1'b0;
      @(posedge clk); #1;
      start_image(2, 2);
      coded_pixel(0, 0, 1'b1, 0, 1'b0);
      coded_pixel(0, 1, 1'b1, 5, 1'b0);
      coded_pixel(1, 0, 1'b1, 5, 1'b0);
      coded_pixel(1, 1, 1'b1, 5, 1'b0);
      push(K_DONE, 0, 0, 1'b0, 0);
      wait_idle("t6");
      chk("t6_ack_count", ack_cnt, sent_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
